note_player_seq: RTL and testbench

- Parametrised square-wave note generator with a valid/ready note-input interface.
- Each accepted note carries a half-period and a duration; the block drives `note` high and low in alternation for the duration, then returns to idle and pulses `done`.
- A period of zero encodes a rest, which holds `note` silent for the duration.
- Sits between a song sequencer (the producer of notes) and the audio output pin; it replaces the fixed 8-bit, free-running note player.

---
 rtl/note_player_seq_pkg.sv | 17 +
 rtl/note_player_seq_if.sv | 17 +
 rtl/note_player_seq_counter.sv | 32 +++
 rtl/note_player_seq.sv | 98 +++++++++
 tb/tb_note_player_seq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_player_seq_pkg.sv
// Shared types and default widths for the note player.
//   state_t : 2-bit FSM state encoding, also driven onto the state output.
//   PW_DEF  : default half-period / phase counter width.
//   DW_DEF  : default duration / duration counter width.
package note_player_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        REST = 2'd3
    } state_t;

    localparam int unsigned PW_DEF = 16;
    localparam int unsigned DW_DEF = 16;

endpackage

// File: rtl/note_player_seq_if.sv
// Note request handshake between the song sequencer and the note player.
//   in_val    : note request valid (producer -> player)
//   in_rdy    : player can accept a note (player -> producer)
//   in_period : half-period in cycles, 0 = rest
//   in_dur    : note length in cycles, 0 behaves as 1
interface note_player_seq_if #(
    parameter int unsigned PW = 16,
    parameter int unsigned DW = 16
);
    logic          in_val;
    logic          in_rdy;
    logic [PW-1:0] in_period;
    logic [DW-1:0] in_dur;

    modport master (output in_val, output in_period, output in_dur, input  in_rdy);
    modport slave  (input  in_val, input  in_period, input  in_dur, output in_rdy);
endinterface

// File: rtl/note_player_seq_counter.sv
// Up counter with load-to-one and increment enable.
//   clk, rst : clock, asynchronous active-low reset (clears count)
//   load     : start a new count at 1 (has priority over en)
//   en       : increment by one
//   limit    : terminal value
//   cnt      : current count
//   finish   : cnt has reached limit
module counter_param #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         finish
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= {{(W-1){1'b0}}, 1'b1};
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign finish = (cnt >= limit);

endmodule

// File: rtl/note_player_seq.sv
// Square-wave note generator with valid/ready note input.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   stop  : synchronous abort of the current note (no done pulse)
//   np    : note request interface (in_val/in_rdy/in_period/in_dur)
//   state : current FSM state (note_player_pkg::state_t encoding)
//   note  : square-wave output, high in HIGH state only
//   busy  : note or rest in progress
//   done  : one-cycle pulse after natural completion
module note_player_seq
    import note_player_pkg::*;
#(
    parameter int unsigned PW = PW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stop,
    note_player_seq_if.slave    np,
    output logic [1:0]          state,
    output logic                note,
    output logic                busy,
    output logic                done
);

    state_t        cur;
    logic [PW-1:0] per_q;
    logic [DW-1:0] dur_q;
    logic [DW-1:0] dur_lim;
    logic [PW-1:0] ph_cnt;
    logic [DW-1:0] dur_cnt;
    logic          ph_fin, dur_fin;
    logic          acc, tone, run;
    logic          ph_load, ph_en;

    assign acc     = (cur == IDLE) && np.in_val && !stop;
    assign tone    = (cur == HIGH) || (cur == LOW);
    // Still running next cycle: not aborted and duration not yet reached.
    assign run     = (cur != IDLE) && !stop && !dur_fin;
    assign dur_lim = (dur_q == '0) ? {{(DW-1){1'b0}}, 1'b1} : dur_q;

    assign ph_load = acc || (run && tone && ph_fin);
    assign ph_en   = run && tone && !ph_fin;

    counter_param #(.W(PW)) u_phase (
        .clk    (clk),
        .rst    (rst),
        .load   (ph_load),
        .en     (ph_en),
        .limit  (per_q),
        .cnt    (ph_cnt),
        .finish (ph_fin)
    );

    counter_param #(.W(DW)) u_dur (
        .clk    (clk),
        .rst    (rst),
        .load   (acc),
        .en     (run),
        .limit  (dur_lim),
        .cnt    (dur_cnt),
        .finish (dur_fin)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur   <= IDLE;
            done  <= 1'b0;
            per_q <= '0;
            dur_q <= '0;
        end else begin
            done <= 1'b0;
            if (cur == IDLE) begin
                if (acc) begin
                    per_q <= np.in_period;
                    dur_q <= np.in_dur;
                    if (np.in_period != '0) cur <= HIGH;
                    else                    cur <= REST;
                end
            end else if (stop) begin
                cur <= IDLE;
            end else if (dur_fin) begin
                // Expiry wins over a coincident phase toggle.
                cur  <= IDLE;
                done <= 1'b1;
            end else if (tone && ph_fin) begin
                if (cur == HIGH) cur <= LOW;
                else             cur <= HIGH;
            end
        end
    end

    assign state     = cur;
    assign note      = (cur == HIGH);
    assign busy      = (cur != IDLE);
    assign np.in_rdy = (cur == IDLE);

endmodule

// File: tb/tb_note_player_seq.sv
module tb_note_player_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stop = 1'b0;
    logic stop2 = 1'b0;

    always #5 clk = ~clk;

    note_player_seq_if #(.PW(16), .DW(16)) np1 ();
    note_player_seq_if #(.PW(4),  .DW(5))  np2 ();

    logic [1:0] st1, st2;
    logic note1, busy1, done1;
    logic note2, busy2, done2;

    note_player_seq #(.PW(16), .DW(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .stop  (stop),
        .np    (np1),
        .state (st1),
        .note  (note1),
        .busy  (busy1),
        .done  (done1)
    );

    note_player_seq #(.PW(4), .DW(5)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .stop  (stop2),
        .np    (np2),
        .state (st2),
        .note  (note2),
        .busy  (busy2),
        .done  (done2)
    );

    int checks = 0;
    int errors = 0;

    task automatic test_reset();
        np1.in_val = 1'b0; np1.in_period = '0; np1.in_dur = '0;
        np2.in_val = 1'b0; np2.in_period = '0; np2.in_dur = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (st1 !== 2'd0 || note1 !== 1'b0 || np1.in_rdy !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d note=%b rdy=%b busy=%b done=%b, want 0 0 1 0 0",
                     st1, note1, np1.in_rdy, busy1, done1);
        end
        checks++;
        if (st2 !== 2'd0 || note2 !== 1'b0 || np2.in_rdy !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL reset2: state=%0d note=%b rdy=%b busy=%b done=%b, want 0 0 1 0 0",
                     st2, note2, np2.in_rdy, busy2, done2);
        end
    endtask

    task automatic test_basic_tone();
        logic [5:0] pat;
        pat = 6'b110011;
        np1.in_period = 16'd2; np1.in_dur = 16'd6; np1.in_val = 1'b1;
        @(posedge clk); #1;
        // Garbage on the inputs mid-note must be ignored.
        np1.in_val = 1'b0; np1.in_period = 16'd7; np1.in_dur = 16'd1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (note1 !== pat[5-i] || busy1 !== 1'b1 || np1.in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL basic_note[%0d]: note=%b busy=%b rdy=%b, want %b 1 0",
                         i, note1, busy1, np1.in_rdy, pat[5-i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (st1 !== 2'd0 || done1 !== 1'b1 || note1 !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: state=%0d done=%b note=%b, want 0 1 0", st1, done1, note1);
        end
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b0 || st1 !== 2'd0) begin
            errors++;
            $display("FAIL basic_done_width: done=%b state=%0d, want 0 0", done1, st1);
        end
    endtask

    task automatic test_rest_zero_dur();
        np1.in_period = 16'd0; np1.in_dur = 16'd4; np1.in_val = 1'b1;
        @(posedge clk); #1;
        np1.in_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (st1 !== 2'd3 || note1 !== 1'b0 || busy1 !== 1'b1) begin
                errors++;
                $display("FAIL rest[%0d]: state=%0d note=%b busy=%b, want 3 0 1", i, st1, note1, busy1);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (st1 !== 2'd0 || done1 !== 1'b1) begin
            errors++;
            $display("FAIL rest_end: state=%0d done=%b, want 0 1", st1, done1);
        end
        @(posedge clk); #1;
        np1.in_period = 16'd3; np1.in_dur = 16'd0; np1.in_val = 1'b1;
        @(posedge clk); #1;
        np1.in_val = 1'b0;
        checks++;
        if (note1 !== 1'b1 || st1 !== 2'd1) begin
            errors++;
            $display("FAIL zero_dur_note: note=%b state=%0d, want 1 1", note1, st1);
        end
        @(posedge clk); #1;
        checks++;
        if (st1 !== 2'd0 || done1 !== 1'b1 || note1 !== 1'b0) begin
            errors++;
            $display("FAIL zero_dur_end: state=%0d done=%b note=%b, want 0 1 0", st1, done1, note1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        pat = 4'b1110;
        np1.in_period = 16'd3; np1.in_dur = 16'd4; np1.in_val = 1'b1;
        @(posedge clk); #1;
        np1.in_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (note1 !== pat[3-i]) begin
                errors++;
                $display("FAIL midlevel_note[%0d]: note=%b, want %b", i, note1, pat[3-i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (st1 !== 2'd0 || done1 !== 1'b1 || np1.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midlevel_end: state=%0d done=%b rdy=%b, want 0 1 1", st1, done1, np1.in_rdy);
        end
        // Offer the next note during the done cycle.
        np1.in_period = 16'd1; np1.in_dur = 16'd2; np1.in_val = 1'b1;
        @(posedge clk); #1;
        np1.in_val = 1'b0;
        checks++;
        if (note1 !== 1'b1 || st1 !== 2'd1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: note=%b state=%0d done=%b, want 1 1 0", note1, st1, done1);
        end
        @(posedge clk); #1;
        checks++;
        if (note1 !== 1'b0 || st1 !== 2'd2) begin
            errors++;
            $display("FAIL b2b_second: note=%b state=%0d, want 0 2", note1, st1);
        end
        @(posedge clk); #1;
        checks++;
        if (st1 !== 2'd0 || done1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: state=%0d done=%b, want 0 1", st1, done1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stop();
        logic [6:0] pat;
        pat = 7'b1111100;
        np1.in_period = 16'd5; np1.in_dur = 16'd100; np1.in_val = 1'b1;
        @(posedge clk); #1;
        np1.in_val = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (note1 !== pat[6-i]) begin
                errors++;
                $display("FAIL stop_note[%0d]: note=%b, want %b", i, note1, pat[6-i]);
            end
            if (i < 6) begin
                @(posedge clk); #1;
            end
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        checks++;
        if (st1 !== 2'd0 || done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL stop_abort: state=%0d done=%b busy=%b, want 0 0 0", st1, done1, busy1);
        end
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b0 || st1 !== 2'd0) begin
            errors++;
            $display("FAIL stop_no_done: done=%b state=%0d, want 0 0", done1, st1);
        end
        // stop in IDLE beats in_val.
        stop = 1'b1; np1.in_period = 16'd2; np1.in_dur = 16'd3; np1.in_val = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; np1.in_val = 1'b0;
        checks++;
        if (st1 !== 2'd0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle_block: state=%0d busy=%b, want 0 0", st1, busy1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_note();
        np1.in_period = 16'd5; np1.in_dur = 16'd100; np1.in_val = 1'b1;
        @(posedge clk); #1;
        np1.in_val = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (st1 !== 2'd2 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: state=%0d busy=%b, want 2 1", st1, busy1);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (st1 !== 2'd0 || note1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: state=%0d note=%b busy=%b done=%b, want 0 0 0 0",
                     st1, note1, busy1, done1);
        end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (st1 !== 2'd0 || done1 !== 1'b0 || np1.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after: state=%0d done=%b rdy=%b, want 0 0 1", st1, done1, np1.in_rdy);
        end
    endtask

    task automatic test_width_corner();
        logic exp;
        np2.in_period = 4'd15; np2.in_dur = 5'd31; np2.in_val = 1'b1;
        @(posedge clk); #1;
        np2.in_val = 1'b0;
        for (int i = 0; i < 31; i++) begin
            exp = (i < 15) || (i >= 30);
            checks++;
            if (note2 !== exp || busy2 !== 1'b1) begin
                errors++;
                $display("FAIL width_note[%0d]: note=%b busy=%b, want %b 1", i, note2, busy2, exp);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (st2 !== 2'd0 || done2 !== 1'b1) begin
            errors++;
            $display("FAIL width_end: state=%0d done=%b, want 0 1", st2, done2);
        end
        @(posedge clk); #1;
        checks++;
        if (st2 !== 2'd0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL width_after: state=%0d done=%b, want 0 0", st2, done2);
        end
    endtask

    initial begin
        test_reset();
        test_basic_tone();
        test_rest_zero_dur();
        test_back_to_back();
        test_stop();
        test_reset_mid_note();
        test_width_corner();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
